simple_display_scan: RTL

//  Debug display stage downstream of the SIMPLE CPU top level. Consumes the CPU's

---
 rtl/simple_display_scan.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/simple_display_scan.sv
// simple_display_scan: debug display stage for the SIMPLE CPU.
// Drives a 4-digit multiplexed 7-segment display and 10 status LEDs.
// A debounced push-button steps through eight 16-bit pages of CPU state.
// A hold switch freezes the displayed value.
//
// Ports:
//   clock, reset         system clock; synchronous active-high reset
//   program_counter..r3  16-bit page sources (pages 0..7)
//   cond_register        SZCV flags shown on led[9:6]
//   state_in             CPU phase shown on led[5:3]
//   page_step            raw asynchronous push-button, active-high
//   hold                 1 = freeze displayed value
//   seg_n                active-low segments {dp,g,f,e,d,c,b,a}
//   dig_n                active-low digit enables, bit0 = least significant nibble
//   led                  {cond_register, state_in, page}
//
// Optional feature: define SIMPLE_DISP_ZERO_BLANK_EN to blank leading zero digits.
module simple_display_scan #(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] program_counter,
    input  logic [15:0] instruction_reg,
    input  logic [15:0] data_register,
    input  logic [15:0] mdr,
    input  logic [15:0] r0,
    input  logic [15:0] r1,
    input  logic [15:0] r2,
    input  logic [15:0] r3,
    input  logic [3:0]  cond_register,
    input  logic [2:0]  state_in,
    input  logic        page_step,
    input  logic        hold,
    output logic [7:0]  seg_n,
    output logic [3:0]  dig_n,
    output logic [9:0]  led
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned SCAN_LAST = SCAN_DIV - 1;
    localparam int unsigned DB_W    = $clog2((DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 2);
    localparam int unsigned DB_LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              db_level_q, db_level_d;
    logic [2:0]        page_q, page_d;
    logic              reload_q, reload_d;
    logic [15:0]       shown_q, shown_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        seg_n_q, seg_n_d;
    logic [3:0]        dig_n_q, dig_n_d;
    logic [9:0]        led_q, led_d;

    logic              step_c;
    logic              wrap_c;
    logic [15:0]       page_val_c;
    logic [3:0]        nib_c;
    logic [15:0]       upper_c;

    // Active-low 7-segment hex font, dp off
    function automatic logic [7:0] hex_font(input logic [3:0] n);
        case (n)
            4'h0: hex_font = 8'hC0;
            4'h1: hex_font = 8'hF9;
            4'h2: hex_font = 8'hA4;
            4'h3: hex_font = 8'hB0;
            4'h4: hex_font = 8'h99;
            4'h5: hex_font = 8'h92;
            4'h6: hex_font = 8'h82;
            4'h7: hex_font = 8'hF8;
            4'h8: hex_font = 8'h80;
            4'h9: hex_font = 8'h90;
            4'hA: hex_font = 8'h88;
            4'hB: hex_font = 8'h83;
            4'hC: hex_font = 8'hC6;
            4'hD: hex_font = 8'hA1;
            4'hE: hex_font = 8'h86;
            default: hex_font = 8'h8E;
        endcase
    endfunction

    // Next-state logic for button path, page, snapshot, scan and outputs
    always_comb begin
        sync1_d    = page_step;
        sync2_d    = sync1_q;
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        step_c     = 1'b0;

        // Counter only runs while the synced level disagrees with the accepted one
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_W'(DB_LAST)) begin
                db_level_d = ~db_level_q;
                step_c     = ~db_level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        page_d   = step_c ? page_q + 3'd1 : page_q;
        reload_d = step_c;

        case (page_q)
            3'd0:    page_val_c = program_counter;
            3'd1:    page_val_c = instruction_reg;
            3'd2:    page_val_c = data_register;
            3'd3:    page_val_c = mdr;
            3'd4:    page_val_c = r0;
            3'd5:    page_val_c = r1;
            3'd6:    page_val_c = r2;
            default: page_val_c = r3;
        endcase

        // A page change loads the new page once even while held
        shown_d = (!hold || reload_q) ? page_val_c : shown_q;

        wrap_c     = (scan_cnt_q == SCAN_W'(SCAN_LAST));
        scan_cnt_d = wrap_c ? '0 : scan_cnt_q + 1'b1;
        idx_d      = wrap_c ? idx_q + 2'd1 : idx_q;

        // Blank all digits in the last cycle of a slot to avoid ghosting
        dig_n_d = wrap_c ? 4'b1111 : ~(4'b0001 << idx_q);

        nib_c   = shown_q[{idx_q, 2'b00} +: 4];
        upper_c = shown_q >> {idx_q, 2'b00};
`ifdef SIMPLE_DISP_ZERO_BLANK_EN
        seg_n_d = ((idx_q != 2'd0) && (upper_c == 16'h0000)) ? 8'hFF : hex_font(nib_c);
`else
        seg_n_d = (upper_c[3:0] == nib_c) ? hex_font(nib_c) : 8'hFF;
`endif

        led_d = {cond_register, state_in, page_q};
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
            page_q     <= 3'd0;
            reload_q   <= 1'b0;
            shown_q    <= 16'h0000;
            scan_cnt_q <= '0;
            idx_q      <= 2'd0;
            seg_n_q    <= 8'hFF;
            dig_n_q    <= 4'b1111;
            led_q      <= 10'h000;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
            page_q     <= page_d;
            reload_q   <= reload_d;
            shown_q    <= shown_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_n_q    <= seg_n_d;
            dig_n_q    <= dig_n_d;
            led_q      <= led_d;
        end
    end

    assign seg_n = seg_n_q;
    assign dig_n = dig_n_q;
    assign led   = led_q;

endmodule
